// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register_file write port between ALU and load writeback.
// One registered issue stage; writes to r0 are accepted but dropped and counted.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_WrEn,
    output logic [ADDR_WIDTH-1:0] rf_Aw,
    output logic [DATA_WIDTH-1:0] rf_Dw,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    pri_t                  pri_q, pri_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] aw_q, aw_d;
    logic [DATA_WIDTH-1:0] dw_q, dw_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  grant0, grant1, xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] one;
        one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    always_comb begin
        grant0   = req0_valid && !reset && (!req1_valid || (pri_q == PRI0));
        grant1   = req1_valid && !reset && (!req0_valid || (pri_q == PRI1));
        xfer     = grant0 || grant1;
        sel_addr = grant0 ? req0_addr : req1_addr;
        sel_data = grant0 ? req0_data : req1_data;

        pri_d   = pri_q;
        wr_en_d = 1'b0;
        aw_d    = aw_q;
        dw_d    = dw_q;
        cnt_d   = cnt_q;

        if (xfer) begin
            pri_d = grant0 ? PRI1 : PRI0;
            if (sel_addr != '0) begin
                wr_en_d = 1'b1;
                aw_d    = sel_addr;
                dw_d    = sel_data;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    // ---- issue stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q   <= PRI0;
            wr_en_q <= 1'b0;
            aw_q    <= '0;
            dw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pri_q   <= pri_d;
            wr_en_q <= wr_en_d;
            aw_q    <= aw_d;
            dw_q    <= dw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with reset keeps an in-flight write from committing at the reset edge.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rf_WrEn    = wr_en_q && !reset;
        rf_Aw      = aw_q;
        rf_Dw      = dw_q;
        drop_count = cnt_q;
        hazard_a   = rf_WrEn && (aw_q == rd_addr_a) && (rd_addr_a != '0);
        hazard_b   = rf_WrEn && (aw_q == rd_addr_b) && (rd_addr_b != '0);
    end

endmodule
